// File: rtl/fetch_if.sv
// Instruction memory port of the fetch stage: address out, word and valid back.
interface fetch_if;
    logic [31:0] IMemAddr;
    logic [31:0] IMemRdata;
    logic        IMemValid;

    modport master (output IMemAddr, input IMemRdata, input IMemValid);
    modport slave  (input IMemAddr, output IMemRdata, output IMemValid);
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage: program counter, redirect handling and the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          StallF,
    input  logic          StallD,
    input  logic          FlushD,
    input  logic          PCSrcE,
    input  logic [31:0]   PCTargetE,
    fetch_if.master       imem,
    output logic [31:0]   PCF,
    output logic [31:0]   InstrD,
    output logic [31:0]   PCD,
    output logic [31:0]   PCPlus4D,
    output logic          ValidD,
    output logic          MisalignD
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        misalign_f;
    logic        advance;
    logic        capture;
    logic [31:0] pc_plus4_f;

    assign pc_plus4_f    = PCF + 32'd4;
    assign imem.IMemAddr = PCF;

    // The word at PCF is consumed only when nothing will cause it to be refetched or discarded.
    assign advance = !PCSrcE && !StallF && imem.IMemValid;
    assign capture = advance && !FlushD && !StallD;

    always_ff @(posedge clk) begin
        if (reset) begin
            PCF        <= RESET_PC;
            misalign_f <= 1'b0;
        end else if (PCSrcE) begin
            PCF        <= {PCTargetE[31:2], 2'b00};
            misalign_f <= |PCTargetE[1:0];
        end else if (advance) begin
            // The flag belongs to the word at PCF, so it drops as soon as fetch moves on.
            PCF        <= pc_plus4_f;
            misalign_f <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            InstrD    <= NOP;
            PCD       <= 32'd0;
            PCPlus4D  <= 32'd0;
            ValidD    <= 1'b0;
            MisalignD <= 1'b0;
        end else if (StallD) begin
            InstrD    <= InstrD;
        end else if (capture) begin
            InstrD    <= imem.IMemRdata;
            PCD       <= PCF;
            PCPlus4D  <= pc_plus4_f;
            ValidD    <= 1'b1;
            MisalignD <= misalign_f;
        end else begin
            InstrD    <= NOP;
            PCD       <= 32'd0;
            PCPlus4D  <= 32'd0;
            ValidD    <= 1'b0;
            MisalignD <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus random bench for fetch_stage, two instances (RESET_PC 0 and 0xFFFFFFFC).
module tb_fetch_stage;
    typedef struct {
        logic [31:0] pc;
        logic        mis;
        logic [31:0] instr;
        logic [31:0] pcd;
        logic [31:0] pc4;
        logic        vd;
        logic        md;
    } model_t;

    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushD, PCSrcE, IMemValid;
    logic [31:0] PCTargetE;
    logic [31:0] PCF0, InstrD0, PCD0, PCPlus4D0, PCF1, InstrD1, PCD1, PCPlus4D1;
    logic        ValidD0, MisalignD0, ValidD1, MisalignD1;
    int          total = 0;
    int          passed = 0;
    model_t      m0, m1;

    fetch_if bus0 ();
    fetch_if bus1 ();

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h00A0_0113;
            32'h8:   return 32'h00F0_0193;
            32'hC:   return 32'h0140_0213;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
        endcase
    endfunction

    assign bus0.IMemValid = IMemValid;
    assign bus1.IMemValid = IMemValid;
    assign bus0.IMemRdata = mem(bus0.IMemAddr);
    assign bus1.IMemRdata = mem(bus1.IMemAddr);

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem(bus0.master), .PCF(PCF0),
        .InstrD(InstrD0), .PCD(PCD0), .PCPlus4D(PCPlus4D0), .ValidD(ValidD0), .MisalignD(MisalignD0));

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem(bus1.master), .PCF(PCF1),
        .InstrD(InstrD1), .PCD(PCD1), .PCPlus4D(PCPlus4D1), .ValidD(ValidD1), .MisalignD(MisalignD1));

    // Reference: one edge of behaviour from the priority rules of the fetch stage.
    function automatic model_t nxt(input model_t s, input logic [31:0] rpc);
        model_t n = s;
        model_t bub;
        bub.pc = s.pc; bub.mis = s.mis;
        bub.instr = 32'h13; bub.pcd = 0; bub.pc4 = 0; bub.vd = 0; bub.md = 0;
        if (reset) begin
            n = bub; n.pc = rpc; n.mis = 0;
            return n;
        end
        if (FlushD) n = bub;
        else if (StallD) n = s;
        else if (StallF || !IMemValid || PCSrcE) n = bub;
        else begin
            n.instr = mem(s.pc); n.pcd = s.pc; n.pc4 = s.pc + 4; n.vd = 1; n.md = s.mis;
        end
        if (PCSrcE) begin
            n.pc = PCTargetE & 32'hFFFF_FFFC; n.mis = (PCTargetE % 4) != 0;
        end else if (!StallF && IMemValid) begin
            n.pc = s.pc + 4; n.mis = 0;
        end else begin
            n.pc = s.pc; n.mis = s.mis;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    endtask

    task automatic step(input logic r, sf, sd, fd, ps, input logic [31:0] tgt, input logic v);
        reset = r; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt; IMemValid = v;
        m0 = nxt(m0, 32'h0000_0000);
        m1 = nxt(m1, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        chk("PCF0", PCF0, m0.pc);           chk("IMemAddr0", bus0.IMemAddr, m0.pc);
        chk("InstrD0", InstrD0, m0.instr);  chk("PCD0", PCD0, m0.pcd);
        chk("PCPlus4D0", PCPlus4D0, m0.pc4);
        chk("ValidD0", {31'd0, ValidD0}, {31'd0, m0.vd});
        chk("MisalignD0", {31'd0, MisalignD0}, {31'd0, m0.md});
        chk("PCF1", PCF1, m1.pc);           chk("InstrD1", InstrD1, m1.instr);
        chk("PCD1", PCD1, m1.pcd);          chk("PCPlus4D1", PCPlus4D1, m1.pc4);
        chk("ValidD1", {31'd0, ValidD1}, {31'd0, m1.vd});
        chk("MisalignD1", {31'd0, MisalignD1}, {31'd0, m1.md});
    endtask

    initial begin
        m0 = '{default: '0};
        m1 = '{default: '0};
        // reset, then straight-line fetch
        step(1, 0, 0, 0, 0, 0, 1);
        chk("rst_pc0", PCF0, 32'h0);
        chk("rst_pc1", PCF1, 32'hFFFF_FFFC);
        chk("rst_instr", InstrD0, 32'h13);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("wrap_pc1", PCF1, 32'h0);
        chk("wrap_pc4d1", PCPlus4D1, 32'h0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("first_instr", InstrD0, 32'h00A0_0113);
        chk("pc_at_8", PCF0, 32'h8);
        // three WAIT cycles at 0x8
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        chk("wait_hold", PCF0, 32'h8);
        chk("wait_bubble", {31'd0, ValidD0}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("after_wait", PCD0, 32'h8);
        // full stall, then fetch-only stall
        step(0, 1, 1, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0, 0, 1);
        chk("stall_pcd", PCD0, 32'h8);
        step(0, 1, 0, 0, 0, 0, 1);
        chk("stallf_bubble", InstrD0, 32'h13);
        // redirects
        step(0, 1, 0, 0, 1, 32'h100, 1);
        chk("redir_pc", PCF0, 32'h100);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 1, 1, 32'h180, 1);
        chk("flush_over_stall", {31'd0, ValidD0}, 32'd0);
        step(0, 0, 0, 0, 1, 32'h203, 1);
        chk("misalign_pc", PCF0, 32'h200);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("misalign_set", {31'd0, MisalignD0}, 32'd1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("misalign_clear", {31'd0, MisalignD0}, 32'd0);
        // reset during WAIT
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("midrst_pc", PCF0, 32'h0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), $urandom(),
                 ($urandom_range(0, 3) != 0));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
